// File: rtl/ahb_master_req_ctrl.sv
// AHB master request/transfer sequencer: requests the bus, issues the
// NONSEQ/SEQ address beats of a burst, and runs the overlapping data phase.

package ahb_master_req_ctrl_pkg;
    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_type;
endpackage

// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// ADDR  | hreq high, presenting address beats until the last one is granted
// DRAIN | hreq low, waiting for the final data phase to complete
module ahb_master_req_ctrl
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int PRIOR_BIT  = 2
) (
    input  logic                  hclk_i,
    input  logic                  hreset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic                  cmd_write_i,
    input  hburst_type            cmd_burst_i,
    input  logic [4:0]            cmd_len_i,
    input  logic [PRIOR_BIT-1:0]  prior_cfg_i,
    input  logic [31:0]           wdata_i,
    output logic                  wdata_ready_o,
    output logic                  hreq_o,
    output logic [PRIOR_BIT-1:0]  hprior_o,
    input  logic                  hgrant_i,
    input  logic                  hready_i,
    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic [1:0]            htrans_o,
    output hburst_type            hburst_o,
    output logic                  hwrite_o,
    output logic [31:0]           hwdata_o,
    input  logic [31:0]           hrdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_last_o
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [4:0]              cnt_q;
    logic [4:0]              last_cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    hburst_type              burst_q;
    logic                    write_q;
    logic [31:0]             hwdata_q;
    logic                    dph_v_q;
    logic                    dph_write_q;
    logic                    dph_last_q;

    logic                    cmd_take;
    logic                    accept;
    logic                    last_beat;
    logic                    complete;

    // Index of the final beat; out-of-range INCR lengths are clamped so cnt stays within 0..15.
    function automatic logic [4:0] beats_m1(hburst_type b, logic [4:0] len);
        logic [4:0] r;
        case (b)
            HB_SINGLE:          r = 5'd0;
            HB_INCR: begin
                if (len == 5'd0)      r = 5'd0;
                else if (len > 5'd16) r = 5'd15;
                else                  r = len - 5'd1;
            end
            HB_WRAP4, HB_INCR4: r = 5'd3;
            HB_WRAP8, HB_INCR8: r = 5'd7;
            default:            r = 5'd15;
        endcase
        return r;
    endfunction

    // Wrapping bursts only let the bits inside the burst boundary move.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(logic [ADDR_WIDTH-1:0] a, hburst_type b);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = a + ADDR_WIDTH'(4);
        mask = '1;
        case (b)
            HB_WRAP4:  mask = {{(ADDR_WIDTH-4){1'b0}}, 4'hF};
            HB_WRAP8:  mask = {{(ADDR_WIDTH-5){1'b0}}, 5'h1F};
            HB_WRAP16: mask = {{(ADDR_WIDTH-6){1'b0}}, 6'h3F};
            default:   mask = '1;
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    assign cmd_take  = (state_q == S_IDLE) & cmd_valid_i;
    assign accept    = (state_q == S_ADDR) & hgrant_i;
    assign last_beat = (cnt_q == last_cnt_q);
    assign complete  = dph_v_q & hready_i;

    // State register.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid_i)          state_d = S_ADDR;
            S_ADDR:  if (accept && last_beat)  state_d = S_DRAIN;
            S_DRAIN: if (complete)             state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        cmd_ready_o = 1'b0;
        hreq_o      = 1'b0;
        htrans_o    = HTRANS_IDLE;
        case (state_q)
            S_IDLE: cmd_ready_o = 1'b1;
            S_ADDR: begin
                hreq_o   = 1'b1;
                htrans_o = (cnt_q == 5'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            end
            default: ;
        endcase
    end

    // Command latch, beat counter, address walker and data-phase tracking.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            cnt_q       <= 5'd0;
            last_cnt_q  <= 5'd0;
            addr_q      <= '0;
            burst_q     <= HB_SINGLE;
            write_q     <= 1'b0;
            hwdata_q    <= 32'd0;
            dph_v_q     <= 1'b0;
            dph_write_q <= 1'b0;
            dph_last_q  <= 1'b0;
        end else begin
            if (cmd_take) begin
                addr_q     <= cmd_addr_i;
                burst_q    <= cmd_burst_i;
                write_q    <= cmd_write_i;
                cnt_q      <= 5'd0;
                last_cnt_q <= beats_m1(cmd_burst_i, cmd_len_i);
            end
            if (accept) begin
                cnt_q  <= cnt_q + 5'd1;
                addr_q <= next_addr(addr_q, burst_q);
                if (write_q) hwdata_q <= wdata_i;
            end
            if (accept) begin
                dph_v_q     <= 1'b1;
                dph_write_q <= write_q;
                dph_last_q  <= last_beat;
            end else if (complete) begin
                dph_v_q <= 1'b0;
            end
        end
    end

    assign hprior_o      = prior_cfg_i;
    assign haddr_o       = addr_q;
    assign hburst_o      = burst_q;
    assign hwrite_o      = write_q;
    assign hwdata_o      = hwdata_q;
    assign wdata_ready_o = accept & write_q;
    assign rsp_valid_o   = complete;
    assign rsp_last_o    = complete & dph_last_q;
    assign rsp_rdata_o   = dph_write_q ? 32'd0 : hrdata_i;

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Bench for ahb_master_req_ctrl: directed scenarios plus randomized bursts,
// checked every cycle against a beat-list model of the burst.
module tb_ahb_master_req_ctrl;
    import ahb_master_req_ctrl_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    hburst_type  cmd_burst;
    logic [4:0]  cmd_len;
    logic [1:0]  prior_cfg, hprior;
    logic [31:0] wdata, hwdata, hrdata, rsp_rdata, haddr;
    logic        wdata_ready, hreq, hgrant, hready, hwrite;
    logic [1:0]  htrans;
    hburst_type  hburst;
    logic        rsp_valid, rsp_last;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hwdata = 32'd0;

    always #5 hclk = ~hclk;

    ahb_master_req_ctrl #(.ADDR_WIDTH(32), .PRIOR_BIT(2)) dut (
        .hclk_i(hclk), .hreset_i(hreset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_write_i(cmd_write),
        .cmd_burst_i(cmd_burst), .cmd_len_i(cmd_len),
        .prior_cfg_i(prior_cfg), .wdata_i(wdata), .wdata_ready_o(wdata_ready),
        .hreq_o(hreq), .hprior_o(hprior), .hgrant_i(hgrant), .hready_i(hready),
        .haddr_o(haddr), .htrans_o(htrans), .hburst_o(hburst), .hwrite_o(hwrite),
        .hwdata_o(hwdata), .hrdata_i(hrdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_last_o(rsp_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_beats(hburst_type b, int len);
        case (b)
            HB_SINGLE:          return 1;
            HB_INCR:            return (len == 0) ? 1 : len;
            HB_WRAP4, HB_INCR4: return 4;
            HB_WRAP8, HB_INCR8: return 8;
            default:            return 16;
        endcase
    endfunction

    function automatic logic [31:0] model_addr(logic [31:0] start, hburst_type b, int len, int k);
        logic [31:0] bnd, base;
        if (b == HB_WRAP4 || b == HB_WRAP8 || b == HB_WRAP16) begin
            bnd  = 32'(model_beats(b, len) * 4);
            base = start - (start % bnd);
            return base + ((start - base + 32'(4 * k)) % bnd);
        end
        return start + 32'(4 * k);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hreq"}, 32'(hreq), 32'd0);
        chk({tag, "_htrans"}, 32'(htrans), 32'd0);
        chk({tag, "_haddr"}, haddr, 32'd0);
        chk({tag, "_hburst"}, 32'(hburst), 32'(HB_SINGLE));
        chk({tag, "_hwrite"}, 32'(hwrite), 32'd0);
        chk({tag, "_hwdata"}, hwdata, 32'd0);
        chk({tag, "_wdata_ready"}, 32'(wdata_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_last"}, 32'(rsp_last), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    // Runs one command; entered and left at posedge+1.
    task automatic do_cmd(input logic [31:0] a, input logic w, input hburst_type b, input int len,
                          input int gpct, input int rpct, input int gdelay,
                          input int stall_beat, input int stall_n, input bit hold_valid,
                          input int rst_beat, input logic [31:0] wfix);
        int  beats;
        int  k, nrsp, cyc, stalls;
        bit  pend, pend_last, pend_w, inaddr, g, r, rst_now;
        beats = model_beats(b, len);
        k = 0; nrsp = 0; cyc = 0; stalls = 0;
        pend = 0; pend_last = 0; pend_w = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_burst = b; cmd_len = 5'(len);
        hgrant = 1'b0; hready = 1'b1;
        @(negedge hclk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge hclk); #1;
        if (!hold_valid) cmd_valid = 1'b0;
        while (nrsp < beats) begin
            if (cyc > 3000) begin
                chk("burst_timeout", 32'(nrsp), 32'(beats));
                break;
            end
            inaddr  = (k < beats);
            r       = ($urandom_range(99) < rpct);
            g       = r && inaddr && (cyc >= 1 + gdelay) && ($urandom_range(99) < gpct);
            rst_now = (rst_beat >= 0) && inaddr && (k == rst_beat);
            if (inaddr && k == stall_beat && stalls < stall_n) begin
                r = 0; g = 0; stalls++;
            end
            if (rst_now) g = 0;
            hready = r; hgrant = g; hreset = rst_now;
            wdata  = (wfix != 0) ? wfix : $urandom;
            hrdata = $urandom;
            @(negedge hclk);
            chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            chk("hreq", 32'(hreq), 32'(inaddr));
            chk("htrans", 32'(htrans), inaddr ? ((k == 0) ? 32'd2 : 32'd3) : 32'd0);
            chk("hprior", 32'(hprior), 32'(prior_cfg));
            if (inaddr) begin
                chk("haddr", haddr, model_addr(a, b, len, k));
                chk("hburst", 32'(hburst), 32'(b));
                chk("hwrite", 32'(hwrite), 32'(w));
            end
            chk("wdata_ready", 32'(wdata_ready), 32'(g && w));
            chk("rsp_valid", 32'(rsp_valid), 32'(pend && r));
            chk("rsp_last", 32'(rsp_last), 32'(pend && r && pend_last));
            if (pend && r && !pend_w) chk("rsp_rdata", rsp_rdata, hrdata);
            chk("hwdata", hwdata, exp_hwdata);
            if (rst_now) begin
                @(posedge hclk); #1;
                hreset = 1'b0; cmd_valid = 1'b0; hgrant = 1'b0; hready = 1'b1;
                exp_hwdata = 32'd0;
                @(negedge hclk);
                check_reset_outputs("rst_mid");
                for (int i = 0; i < 3; i++) begin
                    @(negedge hclk);
                    chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
                    chk("rst_idle_ready", 32'(cmd_ready), 32'd1);
                end
                @(posedge hclk); #1;
                return;
            end
            if (pend && r) begin nrsp++; pend = 0; end
            if (g) begin
                pend = 1; pend_last = (k == beats - 1); pend_w = w;
                if (w) exp_hwdata = wdata;
                k++;
            end
            @(posedge hclk); #1;
            cyc++;
        end
        hgrant = 1'b0;
        hready = 1'b1;
    endtask

    initial begin
        hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
        cmd_burst = HB_SINGLE; cmd_len = 5'd1; prior_cfg = 2'b10;
        wdata = '0; hgrant = 1'b0; hready = 1'b1; hrdata = '0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        check_reset_outputs("por");
        chk("por_hprior", 32'(hprior), 32'd2);
        @(posedge hclk); #1;
        hreset = 1'b0;

        // single write
        do_cmd(32'h100, 1'b1, HB_SINGLE, 1, 100, 100, 0, -1, 0, 1'b0, -1, 32'hA5A5_A5A5);
        // INCR4 read, two wait cycles on beat 1
        do_cmd(32'h200, 1'b0, HB_INCR4, 4, 100, 100, 0, 1, 2, 1'b0, -1, 32'd0);
        // WRAP8 wrap-around
        do_cmd(32'h118, 1'b0, HB_WRAP8, 8, 100, 100, 0, -1, 0, 1'b0, -1, 32'd0);
        // WRAP4 / WRAP16 near boundary
        do_cmd(32'h2C, 1'b1, HB_WRAP4, 4, 100, 100, 0, -1, 0, 1'b0, -1, 32'd0);
        do_cmd(32'h7C, 1'b0, HB_WRAP16, 16, 100, 100, 0, -1, 0, 1'b0, -1, 32'd0);
        // delayed grant
        do_cmd(32'h300, 1'b1, HB_INCR, 2, 100, 100, 5, -1, 0, 1'b0, -1, 32'd0);
        // INCR with length 0 and length 16
        do_cmd(32'h340, 1'b0, HB_INCR, 0, 100, 100, 0, -1, 0, 1'b0, -1, 32'd0);
        do_cmd(32'h380, 1'b1, HB_INCR, 16, 100, 100, 0, -1, 0, 1'b0, -1, 32'd0);
        // busy command held through INCR16, then accepted
        do_cmd(32'h400, 1'b1, HB_INCR16, 16, 100, 100, 0, -1, 0, 1'b1, -1, 32'd0);
        do_cmd(32'h500, 1'b0, HB_SINGLE, 1, 100, 100, 0, -1, 0, 1'b0, -1, 32'd0);
        // reset at beat 3 of INCR8, then normal command
        do_cmd(32'h600, 1'b1, HB_INCR8, 8, 100, 100, 0, -1, 0, 1'b0, 3, 32'd0);
        do_cmd(32'h700, 1'b1, HB_SINGLE, 1, 100, 100, 0, -1, 0, 1'b0, -1, 32'd0);

        // randomized bursts with random grant/ready gaps
        for (int n = 0; n < 30; n++) begin
            hburst_type rb;
            rb = hburst_type'($urandom_range(7));
            prior_cfg = 2'($urandom_range(3));
            do_cmd($urandom & 32'hFFFF_FFFC, 1'($urandom_range(1)), rb,
                   $urandom_range(16), 60, 75, $urandom_range(3), -1, 0, 1'b0, -1, 32'd0);
        end

        @(negedge hclk);
        chk("final_idle", 32'(cmd_ready), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
